// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch stage of the RV32i pipeline.
//
// Holds the program counter and presents it to the combinational instruction
// memory. Captures the returned word into the IF/ID register. Honours
// load-use stalls and EX-resolved redirects, and injects NOP bubbles into
// decode on flush or redirect.
//
// Optional feature macro: FETCH_PERF_EN adds the Fetch_Count and Stall_Count
// performance counters. When it is undefined, those ports and their logic
// are absent.
//
// Ports:
//   CLK, RST      clock; synchronous active-high reset
//   Stall_F       hold PC and IF/ID
//   Flush_D       load a bubble into IF/ID
//   PC_Src        redirect PC to PC_Target (word-aligned)
//   PC_Target     redirect address from EX
//   Instr         instruction memory read data for PC_Out
//   PC_Out        current fetch address
//   Instr_D       IF/ID instruction
//   PC_D          PC of Instr_D
//   PC_Plus4_D    PC_D + 4 (link address)
//   Valid_D       Instr_D is a real fetched instruction
//   Misalign_D    redirect leading to PC_D had a misaligned target
//   Fetch_Count   valid IF/ID loads            (FETCH_PERF_EN only)
//   Stall_Count   stalled cycles               (FETCH_PERF_EN only)
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        Stall_F,
   input  logic        Flush_D,
   input  logic        PC_Src,
   input  logic [31:0] PC_Target,
   input  logic [31:0] Instr,
   output logic [31:0] PC_Out,
   output logic [31:0] Instr_D,
   output logic [31:0] PC_D,
   output logic [31:0] PC_Plus4_D,
   output logic        Valid_D,
`ifdef FETCH_PERF_EN
   output logic        Misalign_D,
   output logic [31:0] Fetch_Count,
   output logic [31:0] Stall_Count
`else
   output logic        Misalign_D
`endif
);

   // Misaligned-target flag waiting for the first fetch from the redirected PC.
   logic redir_misalign;

   logic bubble;
   logic load;

   // A redirect always bubbles decode: the word fetched this cycle is wrong-path.
   assign bubble = Flush_D | PC_Src;
   assign load   = ~bubble & ~Stall_F;

   // ---- PC register ----
   always_ff @(posedge CLK) begin
      if (RST) begin
         PC_Out <= RESET_PC;
      end else if (PC_Src) begin
         // Redirect beats a stall: the branch is older than the stalled instruction.
         PC_Out <= {PC_Target[31:2], 2'b00};
      end else if (!Stall_F) begin
         PC_Out <= PC_Out + 32'd4;
      end
   end

   // ---- redirect misalignment tracking ----
   always_ff @(posedge CLK) begin
      if (RST) begin
         redir_misalign <= 1'b0;
      end else if (PC_Src) begin
         redir_misalign <= |PC_Target[1:0];
      end else if (load) begin
         redir_misalign <= 1'b0;
      end
   end

   // ---- IF/ID register ----
   always_ff @(posedge CLK) begin
      if (RST) begin
         Instr_D    <= NOP_INSTR;
         PC_D       <= 32'd0;
         PC_Plus4_D <= 32'd4;
         Valid_D    <= 1'b0;
         Misalign_D <= 1'b0;
      end else if (bubble) begin
         // PC_D / PC_Plus4_D / Misalign_D are meaningless for a bubble; hold them.
         Instr_D <= NOP_INSTR;
         Valid_D <= 1'b0;
      end else if (load) begin
         Instr_D    <= Instr;
         PC_D       <= PC_Out;
         PC_Plus4_D <= PC_Out + 32'd4;
         Valid_D    <= 1'b1;
         Misalign_D <= redir_misalign;
      end
   end

`ifdef FETCH_PERF_EN
   // ---- performance counters ----
   always_ff @(posedge CLK) begin
      if (RST) begin
         Fetch_Count <= 32'd0;
         Stall_Count <= 32'd0;
      end else begin
         if (load) begin
            Fetch_Count <= Fetch_Count + 32'd1;
         end
         if (Stall_F && !PC_Src) begin
            Stall_Count <= Stall_Count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the RV32i pipeline. Holds the program counter and drives `PC_Out` to the combinational `instruction_memory`. Captures the returned `Instr` into the IF/ID pipeline register. Handles hazard stalls from the hazard unit and branch/jump redirects resolved in EX, and inserts NOP bubbles into decode when flushed.

## Interface

**Parameters**

- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, default 32'h0000_0013 (`addi x0,x0,0`): word placed in `Instr_D` for bubbles and on reset.

**Ports** (direction, width, meaning)

- Clocking and reset: one clock; reset is synchronous and active-high.
  - `CLK`, in, 1: clock, all state updates on rising edge.
  - `RST`, in, 1: reset.
- Hazard and redirect inputs:
  - `Stall_F`, in, 1: hold PC and the IF/ID register (load-use hazard).
  - `Flush_D`, in, 1: load a bubble into IF/ID.
  - `PC_Src`, in, 1: redirect the PC to `PC_Target` (taken branch / JAL / JALR).
  - `PC_Target`, in, 32: redirect address from EX.
- Memory interface:
  - `Instr`, in, 32: combinational read data from `instruction_memory` for the current `PC_Out`.
  - `PC_Out`, out, 32: current fetch address to `instruction_memory`.
- IF/ID register outputs:
  - `Instr_D`, out, 32: IF/ID instruction.
  - `PC_D`, out, 32: PC of `Instr_D`.
  - `PC_Plus4_D`, out, 32: `PC_D + 4`, for JAL/JALR link.
  - `Valid_D`, out, 1: `Instr_D` is a real fetched instruction.
  - `Misalign_D`, out, 1: the redirect that produced `PC_D` had `PC_Target[1:0] != 0`.
- Counters (only with `FETCH_PERF_EN`):
  - `Fetch_Count`, out, 32: count of valid instructions loaded into IF/ID.
  - `Stall_Count`, out, 32: count of stalled cycles.

## Operation

- PC register `PC_Out` is updated every rising edge. Priority is highest first:
  1. `RST`: `PC_Out <= RESET_PC`.
  2. `PC_Src`: `PC_Out <= {PC_Target[31:2], 2'b00}`. A redirect overrides `Stall_F`, because the branch is older than the stalled instruction.
  3. `Stall_F`: hold.
  4. Otherwise: `PC_Out <= PC_Out + 4`, mod 2^32. 32'hFFFF_FFFC wraps to 0 with no flag.
- IF/ID register update, highest priority first:
  1. `RST`: `Instr_D = NOP_INSTR`, `PC_D = 0`, `PC_Plus4_D = 4`, `Valid_D = 0`, `Misalign_D = 0`.
  2. `Flush_D` or `PC_Src`: bubble. `Instr_D = NOP_INSTR`, `Valid_D = 0`, `PC_D` and `PC_Plus4_D` are don't-care (hold). The wrong-path word fetched this cycle is discarded. Flush overrides `Stall_F`.
  3. `Stall_F`: hold all IF/ID fields.
  4. Otherwise: `Instr_D <= Instr`, `PC_D <= PC_Out`, `PC_Plus4_D <= PC_Out + 4`, `Valid_D <= 1`.
- `Misalign_D`:
  - A one-bit `redir_misalign` flag is set on a redirect edge when `PC_Target[1:0] != 0`.
  - It is copied into `Misalign_D` with the first instruction loaded from the redirected PC, then cleared.
  - It is held through stalls. A later redirect overwrites it.
- There is no internal state machine beyond PC, IF/ID and `redir_misalign`. All outputs are registered.

## Timing

- The instruction memory is combinational, so `Instr` is valid in the same cycle as `PC_Out`. Fetch latency is one edge from `PC_Out` to `Instr_D`.
- Reset sequence:
  - Edge with `RST = 1`: `PC_Out = RESET_PC`.
  - First edge with `RST = 0`: `Instr_D = mem[RESET_PC]`, `Valid_D = 1`, `PC_Out = RESET_PC + 4`.
- Redirect penalty:
  - `PC_Src` high at edge N gives `Valid_D = 0` after N.
  - The target instruction appears in `Instr_D` after edge N+1.
  - The upstream EX-stage flush of the decode instruction is handled by the hazard unit, not here.
- Stall: while `Stall_F` is high, `PC_Out` and all IF/ID outputs are bit-stable. Fetch resumes on the first edge after it falls.
- `RST` asserted mid-stream takes effect at the next edge and overrides all other inputs.

## Configuration

- `FETCH_PERF_EN` defined:
  - `Fetch_Count` increments on every edge where IF/ID loads with `Valid_D <= 1`.
  - `Stall_Count` increments on every edge with `Stall_F = 1` and `PC_Src = 0` and `RST = 0`.
  - Both counters reset to 0 and wrap at 2^32.
- `FETCH_PERF_EN` undefined: the counter ports and logic are absent. Fetch behaviour is otherwise identical.

## Test plan

- **Reset and sequential fetch.** Load the program with `$readmemh("src/program.hex")`, hold `RST` 2 cycles, then release. Required: `PC_Out` = 0, 4, 8, …. `Instr_D` equals `Reference[PC_D[31:2]]` and `Valid_D` = 1 from the first post-reset edge.
- **Stall.** `Stall_F` = 1 for 3 cycles at `PC_Out` = 0x10. Required: `PC_Out` stays 0x10 and `Instr_D` / `PC_D` = 0x0C hold for 3 edges. Then 0x10 is captured; with `FETCH_PERF_EN`, `Stall_Count` = 3.
- **Redirect.** `PC_Src` = 1, `PC_Target` = 0x40 at `PC_Out` = 0x14. Required: next `PC_Out` = 0x40 and `Valid_D` = 0 with `Instr_D` = 0x00000013. The following edge gives `PC_D` = 0x40 and `Valid_D` = 1.
- **Redirect and stall together, misaligned.** `PC_Src` = 1, `Stall_F` = 1, `PC_Target` = 0x22. Required: `PC_Out` = 0x20 and a bubble. Next valid instruction has `PC_D` = 0x20 and `Misalign_D` = 1. The instruction after it has `Misalign_D` = 0.
- **Wrap.** Force a redirect to 0xFFFFFFFC. Required: the next `PC_Out` = 0x00000000, and `PC_Plus4_D` for that fetch = 0x00000000.
- **Mid-run reset.** Assert `RST` one cycle at `PC_Out` = 0x30 with `Stall_F` = 1. Required: `PC_Out` = `RESET_PC`, `Valid_D` = 0, counters = 0.
